unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the Fetch stage (read-only) and the Memory stage (read/write) of the 5-stage pipelined ARM core.
- Sequences each access with a req/ready handshake and produces per-stage stall requests for the hazard unit.
- Data has priority by default; a starvation guard forces a fetch grant after a bounded streak of data grants.
- Branch flushes discard a stale in-flight fetch.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT, 16: cycles in a busy state without MemReady before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstrReqF  in  1  fetch request; held until InstrRdyF.
- PCF  in  32  fetch address.
- FlushF  in  1  branch/PC-write flush; kills the pending or in-flight fetch.
- InstrRdyF  out  1  one-cycle pulse; InstrF valid.
- InstrF  out  32  fetched instruction.
- DataReqM  in  1  data request; held until DataRdyM.
- DataWeM  in  1  1 = store, 0 = load.
- ALUOutM  in  32  data address.
- WriteDataM  in  32  store data.
- DataRdyM  out  1  one-cycle pulse; ReadDataM valid (for a load).
- ReadDataM  out  32  load data.
- StallF  out  1  InstrReqF & ~InstrRdyF (combinational).
- StallM  out  1  DataReqM & ~DataRdyM (combinational).
- MemReq  out  1  memory request; high in busy states.
- MemWe  out  1  registered write enable.
- MemAddr  out  32  registered address.
- MemWData  out  32  registered write data.
- MemRData  in  32  memory read data.
- MemReady  in  1  completes the current memory access.
- MemErr  out  1  sticky timeout flag.

Behaviour:
- FSM states: IDLE, FETCH_BUSY, DATA_BUSY. MemReq = (state != IDLE).
- Reset (async, active-low):
  - State goes to IDLE.
  - MemReq, MemWe, InstrRdyF, DataRdyM and MemErr go to 0.
  - MemAddr, MemWData, InstrF, ReadDataM, streak counter, timeout counter and drop flag go to 0.
  - Reset mid-access abandons the access; the memory must tolerate a MemReq drop.
- Masking in IDLE: a requester whose Rdy is high this cycle is masked, so its held request is not re-issued. A fetch request with FlushF high in the same cycle is not issued.
- Arbitration in IDLE (on the unmasked requests):
  - Only data pending: issue data.
  - Only fetch pending: issue fetch.
  - Both pending: issue fetch if streak == MAX_DATA_STREAK, otherwise issue data.
- Issue:
  - Latch MemAddr (PCF or ALUOutM), MemWe (0 or DataWeM) and MemWData.
  - Go to FETCH_BUSY or DATA_BUSY.
  - Clear the timeout counter.
- Streak counter:
  - Data issue with InstrReqF high: increment, saturating at MAX_DATA_STREAK.
  - Fetch issue: clear.
  - InstrReqF low in IDLE: clear.
- Busy states:
  - MemReady = 1: capture MemRData into InstrF or ReadDataM; go to IDLE; pulse the matching Rdy in the next cycle.
  - Minimum request-to-Rdy latency is 2 cycles (request at cycle 0, MemReq at cycle 1, MemReady at cycle 1, Rdy at cycle 2).
  - Back-to-back accesses cost one IDLE cycle each.
- Flush:
  - FlushF in FETCH_BUSY, or in the completing cycle, sets the drop flag.
  - On completion with the drop flag set: no InstrRdyF pulse, InstrF unchanged, flag cleared.
  - The memory access itself still completes.
  - FlushF has no effect on a data access.
- Timeout (TIMEOUT > 0):
  - The counter increments each busy cycle without MemReady.
  - On reaching TIMEOUT: set MemErr (cleared only by reset), return to IDLE, pulse the Rdy with data 0.
  - A store is considered lost.
- MemReady in IDLE is ignored.
- Stalls are combinational from requests and Rdy, with no added latency.

Test Plan:
1. Fetch only: InstrReqF = 1, PCF = 0x100, MemReady one cycle after MemReq, MemRData = 0xE2811001 -> MemAddr = 0x100, MemWe = 0; InstrRdyF pulses at cycle 2 with InstrF = 0xE2811001; StallF high at cycles 0-1.
2. Store: DataReqM = 1, DataWeM = 1, ALUOutM = 0x40, WriteDataM = 0xDEADBEEF, MemReady after 3 wait cycles -> MemWe = 1, MemWData = 0xDEADBEEF held while MemReq is high; one DataRdyM pulse; StallM is low afterwards.
3. Contention and starvation guard: both requests held, data re-requested continuously, MAX_DATA_STREAK = 4 -> grant order D, D, D, D, F, D...; fetch served on the 5th grant.
4. Flush in flight: fetch issued, FlushF pulsed during FETCH_BUSY, MemReady arrives later -> no InstrRdyF pulse, InstrF unchanged; a new fetch with PCF = 0x200 is then served normally.
5. Timeout: TIMEOUT = 16, data load issued, MemReady never asserted -> after 16 busy cycles MemErr = 1, DataRdyM pulses with ReadDataM = 0, FSM returns to IDLE; MemErr stays 1 until reset.
6. Reset mid-access: reset driven low during DATA_BUSY -> MemReq = 0 immediately (async); all outputs at reset values; after release, a pending fetch is issued cleanly.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between instruction fetch and data access
module unified_mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  input  logic        FlushF,
  output logic        InstrRdyF,
  output logic [31:0] InstrF,
  input  logic        DataReqM,
  input  logic        DataWeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        DataRdyM,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        MemErr
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, FETCH_BUSY, DATA_BUSY} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_streak;
  logic [TW-1:0]  r_to;
  logic           r_drop;
  logic           w_f_pend;
  logic           w_d_pend;
  logic           w_streak_max;
  logic           w_issue_f;
  logic           w_issue_d;
  logic           w_timeout;
  logic           w_done;
  logic           w_drop;
  logic [31:0]    w_rdata;

  // a requester whose Rdy is pulsing this cycle is still holding the request it just had served
  assign w_f_pend     = InstrReqF & ~InstrRdyF & ~FlushF;
  assign w_d_pend     = DataReqM & ~DataRdyM;
  assign w_streak_max = (r_streak == STREAK_MAX);
  assign w_issue_f    = w_f_pend & (~w_d_pend | w_streak_max);
  assign w_issue_d    = w_d_pend & ~w_issue_f;
  assign w_timeout    = TO_EN & (r_to == TO_LAST) & ~MemReady;
  assign w_done       = MemReady | w_timeout;
  assign w_rdata      = MemReady ? MemRData : 32'h0;
  assign w_drop       = r_drop | FlushF;

  assign StallF = InstrReqF & ~InstrRdyF;
  assign StallM = DataReqM & ~DataRdyM;
  assign MemReq = (r_state != IDLE);

  // arbitration, access sequencing, completion capture and timeout abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_streak  <= '0;
      r_to      <= '0;
      r_drop    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= 32'h0;
      MemWData  <= 32'h0;
      InstrF    <= 32'h0;
      ReadDataM <= 32'h0;
      InstrRdyF <= 1'b0;
      DataRdyM  <= 1'b0;
      MemErr    <= 1'b0;
    end else begin
      InstrRdyF <= 1'b0;
      DataRdyM  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!InstrReqF || w_issue_f) r_streak <= '0;
          else if (w_issue_d && !w_streak_max) r_streak <= r_streak + SW'(1);
          if (w_issue_f || w_issue_d) begin
            MemAddr  <= w_issue_f ? PCF : ALUOutM;
            MemWe    <= w_issue_d & DataWeM;
            MemWData <= WriteDataM;
            r_to     <= '0;
            r_state  <= w_issue_f ? FETCH_BUSY : DATA_BUSY;
          end
        end
        FETCH_BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            MemWe   <= 1'b0;
            MemErr  <= MemErr | ~MemReady;
            if (!w_drop) begin
              InstrF    <= w_rdata;
              InstrRdyF <= 1'b1;
            end
          end else begin
            r_to   <= r_to + TW'(1);
            r_drop <= w_drop;
          end
        end
        DATA_BUSY: begin
          if (w_done) begin
            r_state   <= IDLE;
            MemWe     <= 1'b0;
            MemErr    <= MemErr | ~MemReady;
            ReadDataM <= w_rdata;
            DataRdyM  <= 1'b1;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scenario tasks with a completion scoreboard and a behavioural memory
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        InstrReqF = 1'b0;
  logic [31:0] PCF = 32'h0;
  logic        FlushF = 1'b0;
  logic        InstrRdyF;
  logic [31:0] InstrF;
  logic        DataReqM = 1'b0;
  logic        DataWeM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic        DataRdyM;
  logic [31:0] ReadDataM;
  logic        StallF;
  logic        StallM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = 32'h0;
  logic        MemReady = 1'b0;
  logic        MemErr;

  int tests = 0;
  int fails = 0;
  logic [32:0] fq[$];
  logic [32:0] dq[$];
  logic [31:0] grants[$];
  logic        prev_req = 1'b0;
  int          mem_delay = 0;
  bit          mem_hang = 1'b0;
  int          rcnt = 0;

  unified_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .InstrReqF(InstrReqF), .PCF(PCF), .FlushF(FlushF), .InstrRdyF(InstrRdyF), .InstrF(InstrF),
    .DataReqM(DataReqM), .DataWeM(DataWeM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .DataRdyM(DataRdyM), .ReadDataM(ReadDataM), .StallF(StallF), .StallM(StallM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hE2811001 : ((a * 32'd3) ^ 32'h5A5A0000);
  endfunction

  // memory: answers after mem_delay wait cycles, never when mem_hang
  initial forever begin
    @(negedge clk);
    if (!reset || !MemReq || MemReady) begin
      MemReady = 1'b0;
      rcnt = 0;
    end else if (!mem_hang) begin
      if (rcnt == mem_delay) begin
        MemReady = 1'b1;
        MemRData = mem_val(MemAddr);
      end else rcnt++;
    end
  end

  // scoreboard: every Rdy pulse is matched against the oldest expected result
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (MemReq && !prev_req) grants.push_back(MemAddr);
    prev_req = MemReq;
    if (InstrRdyF) begin
      tests++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL instr_unexpected: InstrF=%h, no pulse required", InstrF);
      end else begin
        e = fq.pop_front();
        if (InstrF !== e[31:0]) begin
          fails++;
          $display("FAIL instr_data: got %h, required %h", InstrF, e[31:0]);
        end
      end
    end
    if (DataRdyM) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL data_unexpected: ReadDataM=%h, no pulse required", ReadDataM);
      end else begin
        e = dq.pop_front();
        if (e[32]) begin
          tests++;
          if (ReadDataM !== e[31:0]) begin
            fails++;
            $display("FAIL data_read: got %h, required %h", ReadDataM, e[31:0]);
          end
        end
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({MemReq, MemWe, MemErr, InstrRdyF, DataRdyM} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 00000", {MemReq, MemWe, MemErr, InstrRdyF, DataRdyM});
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({MemAddr, MemWData, InstrF, ReadDataM} !== 128'h0 || {StallF, StallM, MemReq} !== 3'b0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h instr=%h rdata=%h stalls=%b%b req=%b, required all 0",
               MemAddr, MemWData, InstrF, ReadDataM, StallF, StallM, MemReq);
    end
  endtask

  task automatic test_fetch;
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    mem_delay = 0;
    InstrReqF = 1'b1;
    PCF = 32'h100;
    fq.push_back({1'b1, 32'hE2811001});
    #1;
    tests++;
    if (StallF !== 1'b1) begin fails++; $display("FAIL fetch_stall_c0: got %b, required 1", StallF); end
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        tests++;
        if ({MemReq, MemWe, StallF} !== 3'b101 || MemAddr !== 32'h100) begin
          fails++;
          $display("FAIL fetch_issue: req/we/stall=%b addr=%h, required 101 addr=00000100", {MemReq, MemWe, StallF}, MemAddr);
        end
      end
      got = InstrRdyF;
    end
    tests++;
    if (!got || lat != 2) begin fails++; $display("FAIL fetch_latency: got %0d cycles (seen=%0b), required 2", lat, got); end
    tests++;
    if (StallF !== 1'b0) begin fails++; $display("FAIL fetch_stall_c2: got %b, required 0", StallF); end
    InstrReqF = 1'b0;
    @(negedge clk);
    tests++;
    if (InstrRdyF !== 1'b0) begin fails++; $display("FAIL fetch_pulse_width: got %b, required 0", InstrRdyF); end
  endtask

  task automatic test_store;
    int pulses = 0;
    int busy = 0;
    int bad = 0;
    @(negedge clk);
    mem_delay = 3;
    DataReqM = 1'b1;
    DataWeM = 1'b1;
    ALUOutM = 32'h40;
    WriteDataM = 32'hDEADBEEF;
    dq.push_back({1'b0, 32'h0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MemReq) begin
        busy++;
        if (MemWe !== 1'b1 || MemWData !== 32'hDEADBEEF || MemAddr !== 32'h40) bad++;
      end
      if (DataRdyM) begin
        pulses++;
        DataReqM = 1'b0;
        DataWeM = 1'b0;
      end
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL store_hold: %0d bad busy cycles, required 0", bad); end
    tests++;
    if (busy != 4) begin fails++; $display("FAIL store_busy: got %0d cycles, required 4", busy); end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL store_pulses: got %0d, required 1", pulses); end
    tests++;
    if (StallM !== 1'b0) begin fails++; $display("FAIL store_stall_after: got %b, required 0", StallM); end
  endtask

  task automatic test_contention;
    logic [31:0] exp_g [6] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h300, 32'h50};
    int k = 0;
    bit fdone = 0;
    @(negedge clk);
    grants.delete();
    mem_delay = 0;
    DataReqM = 1'b1;
    DataWeM = 1'b0;
    ALUOutM = 32'h40;
    dq.push_back({1'b1, mem_val(32'h40)});
    InstrReqF = 1'b1;
    PCF = 32'h300;
    fq.push_back({1'b1, mem_val(32'h300)});
    for (int i = 0; i < 200 && !(k == 5 && fdone); i++) begin
      @(negedge clk);
      FlushF = 1'b0;
      if (InstrRdyF) begin
        fdone = 1;
        InstrReqF = 1'b0;
      end
      if (DataRdyM) begin
        k++;
        if (k < 5) begin
          ALUOutM = 32'h40 + 32'(4 * k);
          dq.push_back({1'b1, mem_val(ALUOutM)});
          FlushF = InstrReqF;
        end else DataReqM = 1'b0;
      end
    end
    FlushF = 1'b0;
    tests++;
    if (k != 5 || !fdone || grants.size() != 6) begin
      fails++;
      $display("FAIL contention_count: data=%0d fetch=%0b grants=%0d, required 5 1 6", k, fdone, grants.size());
    end
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      tests++;
      if (grants[i] !== exp_g[i]) begin
        fails++;
        $display("FAIL contention_grant%0d: addr %h, required %h", i, grants[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] f_before;
    bit got = 0;
    bit seen_done = 0;
    bit prev_busy = 0;
    @(negedge clk);
    grants.delete();
    mem_delay = 4;
    f_before = InstrF;
    InstrReqF = 1'b1;
    PCF = 32'h180;
    @(negedge clk);
    @(negedge clk);
    FlushF = 1'b1;
    PCF = 32'h200;
    fq.push_back({1'b1, mem_val(32'h200)});
    @(negedge clk);
    FlushF = 1'b0;
    prev_busy = MemReq;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (prev_busy && !MemReq && !seen_done) begin
        seen_done = 1;
        tests++;
        if (InstrRdyF !== 1'b0 || InstrF !== f_before) begin
          fails++;
          $display("FAIL flush_drop: rdy=%b InstrF=%h, required 0 %h", InstrRdyF, InstrF, f_before);
        end
      end
      prev_busy = MemReq;
      got = InstrRdyF;
    end
    InstrReqF = 1'b0;
    tests++;
    if (!got || grants.size() != 2) begin
      fails++;
      $display("FAIL flush_refetch: served=%0b grants=%0d, required 1 2", got, grants.size());
    end else begin
      tests++;
      if (grants[0] !== 32'h180 || grants[1] !== 32'h200) begin
        fails++;
        $display("FAIL flush_addrs: %h %h, required 00000180 00000200", grants[0], grants[1]);
      end
    end
  endtask

  task automatic test_timeout;
    int busy = 0;
    bit got = 0;
    @(negedge clk);
    mem_hang = 1'b1;
    DataReqM = 1'b1;
    DataWeM = 1'b0;
    ALUOutM = 32'h80;
    dq.push_back({1'b1, 32'h0});
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (MemReq) begin
        busy++;
        if (busy == 15) begin
          tests++;
          if (MemErr !== 1'b0) begin fails++; $display("FAIL timeout_early: MemErr=%b, required 0", MemErr); end
        end
      end
      if (DataRdyM) begin
        got = 1;
        tests++;
        if ({MemErr, MemReq} !== 2'b10) begin
          fails++;
          $display("FAIL timeout_abort: err/req=%b, required 10", {MemErr, MemReq});
        end
        DataReqM = 1'b0;
      end
    end
    mem_hang = 1'b0;
    tests++;
    if (!got || busy != 16) begin fails++; $display("FAIL timeout_cycles: got %0d (seen=%0b), required 16", busy, got); end
    @(negedge clk);
    mem_delay = 1;
    DataReqM = 1'b1;
    ALUOutM = 32'h84;
    dq.push_back({1'b1, mem_val(32'h84)});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = DataRdyM;
    end
    DataReqM = 1'b0;
    tests++;
    if (!got || MemErr !== 1'b1) begin fails++; $display("FAIL timeout_sticky: served=%0b MemErr=%b, required 1 1", got, MemErr); end
  endtask

  task automatic test_reset_mid;
    bit got = 0;
    @(negedge clk);
    mem_hang = 1'b1;
    DataReqM = 1'b1;
    DataWeM = 1'b1;
    ALUOutM = 32'hC0;
    WriteDataM = 32'h12345678;
    repeat (3) @(negedge clk);
    tests++;
    if ({MemReq, MemWe} !== 2'b11) begin fails++; $display("FAIL rstmid_busy: req/we=%b, required 11", {MemReq, MemWe}); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({MemReq, MemWe, MemErr, InstrRdyF, DataRdyM} !== 5'b0) begin
      fails++;
      $display("FAIL rstmid_ctrl: got %b, required 00000", {MemReq, MemWe, MemErr, InstrRdyF, DataRdyM});
    end
    tests++;
    if ({MemAddr, MemWData, InstrF, ReadDataM} !== 128'h0) begin
      fails++;
      $display("FAIL rstmid_data: addr=%h wdata=%h instr=%h rdata=%h, required 0", MemAddr, MemWData, InstrF, ReadDataM);
    end
    DataReqM = 1'b0;
    DataWeM = 1'b0;
    mem_hang = 1'b0;
    mem_delay = 0;
    InstrReqF = 1'b1;
    PCF = 32'h240;
    fq.push_back({1'b1, mem_val(32'h240)});
    grants.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = InstrRdyF;
    end
    InstrReqF = 1'b0;
    tests++;
    if (!got || grants.size() == 0 || grants[0] !== 32'h240) begin
      fails++;
      $display("FAIL rstmid_refetch: served=%0b grants=%0d, required fetch of 00000240", got, grants.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_flush();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (fq.size() != 0 || dq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d fetch and %0d data results outstanding, required 0", fq.size(), dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
